// File: rtl/online_pkg.sv
// Shared definitions for the radix-2 online multiplier.
//   - signed-digit encodings {p,n} with value p-n
//   - step-sequencer state type
//   - selection thresholds for the 4-bit residual estimate (2 int, 2 frac bits)
//   - sd_value(): decodes a signed digit to -1/0/+1 ({1,1} reads as 0)
package online_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  // Estimate LSB weighs 1/4, so +/-1/2 is +/-2 in estimate units.
  localparam logic signed [3:0] EST_POS_TH = 4'sd2;
  localparam logic signed [3:0] EST_NEG_TH = -4'sd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_e;

  function automatic logic signed [1:0] sd_value(input logic [1:0] d);
    case (d)
      SD_POS:  return 2'sd1;
      SD_NEG:  return -2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/online_csa.sv
// Carry-save residual adder: two cascaded 3:2 rows forming a 4:2 compressor.
//   a_i, b_i, c_i, d_i : WL-bit addends (two's complement, modulo 2^WL)
//   cin1_i, cin2_i     : carry-ins placed in the free LSB of each carry row
//   sum_o, carry_o     : redundant result, sum_o + carry_o == a+b+c+d+cin1+cin2
module online_csa #(
  parameter int WL = 12
) (
  input  logic [WL-1:0] a_i,
  input  logic [WL-1:0] b_i,
  input  logic [WL-1:0] c_i,
  input  logic [WL-1:0] d_i,
  input  logic          cin1_i,
  input  logic          cin2_i,
  output logic [WL-1:0] sum_o,
  output logic [WL-1:0] carry_o
);

  logic [WL-1:0] s1, maj1, c1, maj2;

  always_comb begin
    s1      = a_i ^ b_i ^ c_i;
    maj1    = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    c1      = {maj1[WL-2:0], cin1_i};
    sum_o   = s1 ^ c1 ^ d_i;
    maj2    = (s1 & c1) | (s1 & d_i) | (c1 & d_i);
    carry_o = {maj2[WL-2:0], cin2_i};
  end

endmodule

// File: rtl/online_sel.sv
// Digit selection for the online multiplier.
//   en_i     : selection enabled (low during the initial online-delay steps)
//   vs_top_i : top 4 bits (2 int, 2 frac) of the sum word
//   vc_top_i : top 4 bits of the carry word
//   z_o      : selected product digit, {p,n} encoding
//   corr_o   : 2-bit value to add to the integer bits of the sum word (-z)
module online_sel
  import online_pkg::*;
(
  input  logic       en_i,
  input  logic [3:0] vs_top_i,
  input  logic [3:0] vc_top_i,
  output logic [1:0] z_o,
  output logic [1:0] corr_o
);

  logic signed [3:0] est;

  always_comb begin
    // Modulo-16 sum is exact: the true estimate always lies in [-2, 1.75].
    est    = vs_top_i + vc_top_i;
    z_o    = SD_ZERO;
    corr_o = 2'b00;
    if (en_i) begin
      if (est >= EST_POS_TH) begin
        z_o    = SD_POS;
        corr_o = 2'b11;
      end else if (est < EST_NEG_TH) begin
        z_o    = SD_NEG;
        corr_o = 2'b01;
      end
    end
  end

endmodule

// File: rtl/online_mult_core.sv
// Radix-2 MSD-first online multiplier recurrence core.
// Consumes one signed digit of x and y per step; after an online delay of
// DELTA steps emits one signed product digit per step, N digits in total.
// Residual W is kept in carry-save form (Ws, Wc), WL bits, 2 integer bits.
//   clk, rst        : clock, synchronous active-high reset
//   start           : begins an operation when idle
//   in_valid        : x_dig / y_dig valid
//   x_dig, y_dig    : operand digits {p,n}
//   in_ready        : digit pair accepted this cycle (LOAD/RUN)
//   z_valid, z_dig  : registered product digit
//   busy            : operation in progress
//   done            : one-cycle pulse, cycle after the last product digit
module online_mult_core
  import online_pkg::*;
#(
  parameter int N     = 8,
  parameter int DELTA = 3,
  parameter int WL    = N + 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [1:0] x_dig,
  input  logic [1:0] y_dig,
  output logic       in_ready,
  output logic       z_valid,
  output logic [1:0] z_dig,
  output logic       busy,
  output logic       done
);

  localparam int JW = $clog2(N + DELTA + 1);
  // Weight of operand digit 0 (2^-1) in the WL-bit residual format.
  localparam logic [WL-1:0] HALF        = WL'(1) << (WL - 3);
  localparam logic [JW-1:0] J_LOAD_END  = JW'(DELTA - 1);
  localparam logic [JW-1:0] J_RUN_END   = JW'(N - 1);
  localparam logic [JW-1:0] J_FLUSH_END = JW'(N + DELTA - 1);

  state_e                 state_q, state_d;
  logic [JW-1:0]          j_q, j_d;
  logic signed [WL-1:0]   ws_q, ws_d, wc_q, wc_d;
  logic signed [WL-1:0]   x_q, x_d, y_q, y_d;
  logic                   zv_q, zv_d;
  logic [1:0]             zd_q, zd_d;
  logic                   last_q, last_d;
  logic                   done_q, done_d;

  logic                   step;
  logic signed [1:0]      xd, yd;
  logic signed [WL-1:0]   unit, x_new, y_new, x_sh, y_sh;
  logic signed [WL-1:0]   term_a, term_b, ws2, wc2;
  logic                   cin1, cin2;
  logic [WL-1:0]          vs, vc;
  logic [1:0]             z_sel, corr, vs_int;

  assign in_ready = (state_q == LOAD) || (state_q == RUN);
  assign busy     = (state_q != IDLE);
  assign step     = (in_ready && in_valid) || (state_q == FLUSH);
  assign z_valid  = zv_q;
  assign z_dig    = zd_q;
  assign done     = done_q;

  // Operand append and operand term H = x_j*Y_old + y_j*X_new, scaled 2^-DELTA
  always_comb begin
    xd = sd_value(x_dig);
    yd = sd_value(y_dig);
    if (state_q == FLUSH) begin
      xd = 2'sd0;
      yd = 2'sd0;
    end
    unit  = $signed(HALF >> j_q);
    x_new = x_q;
    y_new = y_q;
    if (xd == 2'sd1)       x_new = x_q + unit;
    else if (xd == -2'sd1) x_new = x_q - unit;
    if (yd == 2'sd1)       y_new = y_q + unit;
    else if (yd == -2'sd1) y_new = y_q - unit;

    y_sh = y_q >>> DELTA;
    x_sh = x_new >>> DELTA;

    // Negation as one's complement; the +1 enters via the adder carry-ins.
    term_a = '0;
    cin1   = 1'b0;
    if (xd == 2'sd1) begin
      term_a = y_sh;
    end else if (xd == -2'sd1) begin
      term_a = ~y_sh;
      cin1   = 1'b1;
    end
    term_b = '0;
    cin2   = 1'b0;
    if (yd == 2'sd1) begin
      term_b = x_sh;
    end else if (yd == -2'sd1) begin
      term_b = ~x_sh;
      cin2   = 1'b1;
    end

    ws2 = {ws_q[WL-2:0], 1'b0};
    wc2 = {wc_q[WL-2:0], 1'b0};
  end

  online_csa #(.WL(WL)) u_csa (
    .a_i     (ws2),
    .b_i     (term_a),
    .c_i     (term_b),
    .d_i     (wc2),
    .cin1_i  (cin1),
    .cin2_i  (cin2),
    .sum_o   (vs),
    .carry_o (vc)
  );

  online_sel u_sel (
    .en_i     (state_q != LOAD),
    .vs_top_i (vs[WL-1:WL-4]),
    .vc_top_i (vc[WL-1:WL-4]),
    .z_o      (z_sel),
    .corr_o   (corr)
  );

  // W = V - z: only the integer bits of the sum word change.
  assign vs_int = vs[WL-1:WL-2] + corr;

  // Step sequencing and next residual
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    ws_d    = ws_q;
    wc_d    = wc_q;
    x_d     = x_q;
    y_d     = y_q;
    zv_d    = 1'b0;
    zd_d    = SD_ZERO;
    last_d  = 1'b0;
    done_d  = last_q;

    if (state_q == IDLE) begin
      if (start) begin
        state_d = LOAD;
        j_d     = '0;
        ws_d    = '0;
        wc_d    = '0;
        x_d     = '0;
        y_d     = '0;
      end
    end else if (step) begin
      ws_d = {vs_int, vs[WL-3:0]};
      wc_d = vc;
      x_d  = x_new;
      y_d  = y_new;
      j_d  = j_q + 1'b1;
      if (state_q != LOAD) begin
        zv_d = 1'b1;
        zd_d = z_sel;
      end
      case (state_q)
        LOAD:    if (j_q == J_LOAD_END) state_d = RUN;
        RUN:     if (j_q == J_RUN_END)  state_d = FLUSH;
        FLUSH: begin
          if (j_q == J_FLUSH_END) begin
            state_d = IDLE;
            last_d  = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      ws_q    <= '0;
      wc_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      zv_q    <= 1'b0;
      zd_q    <= SD_ZERO;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      ws_q    <= ws_d;
      wc_q    <= wc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      zv_q    <= zv_d;
      zd_q    <= zd_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_online_mult_core.sv
// Scoreboard bench for online_mult_core: the driver pushes the expected
// product per operation, a negedge monitor accumulates z digits and checks
// count, done timing and value when done pulses.
module tb_online_mult_core;

  localparam int N     = 8;
  localparam int DELTA = 3;
  localparam int WL    = N + 4;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [1:0] x_dig, y_dig;
  logic       in_ready, z_valid, busy, done;
  logic [1:0] z_dig;

  online_mult_core #(.N(N), .DELTA(DELTA), .WL(WL)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .x_dig    (x_dig),
    .y_dig    (y_dig),
    .in_ready (in_ready),
    .z_valid  (z_valid),
    .z_dig    (z_dig),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int xi;
    int yi;
    bit exact;
    int s_exp;
    int lat;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_start = 0;
  int done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [1:0] enc(input int d);
    if (d > 0) return 2'b10;
    if (d < 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int zval(input logic [1:0] d);
    if (d == 2'b10) return 1;
    if (d == 2'b01) return -1;
    return 0;
  endfunction

  // Monitor
  int   s_acc = 0;
  int   zc = 0;
  int   last_zc = 0;
  exp_t e;
  int   err;

  always @(negedge clk) begin
    if (rst) begin
      s_acc = 0;
      zc    = 0;
    end else begin
      if (z_valid) begin
        if (zc == 0 && sb.size() > 0 && sb[0].lat >= 0)
          chk("first_z_latency", cyc - t_start, sb[0].lat);
        s_acc   = s_acc * 2 + zval(z_dig);
        zc      = zc + 1;
        last_zc = cyc;
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: done seen with no operation outstanding");
        end else begin
          e = sb.pop_front();
          chk("z_count", zc, N);
          chk("done_gap", cyc - last_zc, 1);
          chk("busy_at_done", int'(busy), 0);
          if (e.exact) begin
            chk("exact_value", s_acc, e.s_exp);
          end else begin
            err = s_acc * 256 - e.xi * e.yi;
            if (err < 0) err = -err;
            checks++;
            if (err > 256) begin
              errors++;
              $display("FAIL error_bound: |z-xy|=%0d, limit 256 (units 2^-16)", err);
            end
          end
        end
        s_acc     = 0;
        zc        = 0;
        done_seen = done_seen + 1;
      end
    end
  end

  // Driver: called at posedge+1 with the core idle.
  task automatic do_op(input int xs[N], input int ys[N], input int gapmax,
                       input bit exact, input int s_exp, input int lat,
                       input bit poke);
    exp_t r;
    int   target, w, g;
    r.xi = 0;
    r.yi = 0;
    for (int k = 0; k < N; k++) begin
      r.xi = r.xi * 2 + xs[k];
      r.yi = r.yi * 2 + ys[k];
    end
    r.exact = exact;
    r.s_exp = s_exp;
    r.lat   = lat;
    sb.push_back(r);
    target  = done_seen + 1;

    start   = 1'b1;
    t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      g = (gapmax > 0) ? int'($urandom_range(gapmax)) : 0;
      in_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      x_dig = enc(xs[k]);
      y_dig = enc(ys[k]);
      if (gapmax > 0 && k[0] && xs[k] == 0) x_dig = 2'b11;
      if (gapmax > 0 && !k[0] && ys[k] == 0) y_dig = 2'b11;
      if (poke && k == 4) start = 1'b1;
      @(negedge clk);
      w = 0;
      while (!in_ready && w < 20) begin @(negedge clk); w++; end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: digit %0d not accepted", k);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    x_dig = 2'b00;
    y_dig = 2'b00;
    if (poke) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    w = 0;
    while (done_seen < target && w < 100) begin @(posedge clk); #1; w++; end
    if (done_seen < target) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: no done within 100 cycles, got %0d done", done_seen);
      sb.delete();
    end
    if (poke) begin
      repeat (3) begin @(posedge clk); #1; end
      chk("idle_after_poke", int'(busy), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int xa[N], ya[N];
  int quiet;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    x_dig = 2'b00;
    y_dig = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_z_valid", int'(z_valid), 0);
    chk("rst_z_dig", int'(z_dig), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // in_valid while idle is ignored
    in_valid = 1'b1;
    x_dig = 2'b10;
    y_dig = 2'b10;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_in_ready", int'(in_ready), 0);
    chk("idle_z_valid", int'(z_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_dig = 2'b00;
    y_dig = 2'b00;

    // 1/2 * 1/2 = 1/4
    xa = '{1, 0, 0, 0, 0, 0, 0, 0};
    ya = '{1, 0, 0, 0, 0, 0, 0, 0};
    do_op(xa, ya, 0, 1'b1, 64, 5, 1'b0);

    // -1/2 * 1/2 = -1/4
    xa = '{-1, 0, 0, 0, 0, 0, 0, 0};
    do_op(xa, ya, 0, 1'b1, -64, 5, 1'b0);

    // (1-2^-8)^2
    xa = '{1, 1, 1, 1, 1, 1, 1, 1};
    ya = '{1, 1, 1, 1, 1, 1, 1, 1};
    do_op(xa, ya, 0, 1'b0, 0, 5, 1'b0);

    // directed vectors with input stalls
    xa = '{1, -1, 0, 1, 1, 0, -1, 1};
    ya = '{0, 1, 1, -1, 0, 1, 0, -1};
    do_op(xa, ya, 3, 1'b0, 0, -1, 1'b0);
    xa = '{-1, -1, -1, -1, -1, -1, -1, -1};
    ya = '{1, 1, 1, 1, 1, 1, 1, 1};
    do_op(xa, ya, 3, 1'b0, 0, -1, 1'b0);
    xa = '{0, 0, 0, 0, 0, 0, 0, 1};
    ya = '{1, 1, 1, 1, 1, 1, 1, 1};
    do_op(xa, ya, 2, 1'b0, 0, -1, 1'b0);
    xa = '{0, 1, 0, 0, 0, 0, 0, 0};
    ya = '{-1, 0, 0, 0, 0, 0, 0, 0};
    do_op(xa, ya, 1, 1'b1, -32, -1, 1'b0);

    // reset in RUN at step j=5, then a normal operation
    xa = '{1, 0, 0, 0, 0, 0, 0, 0};
    ya = '{1, 0, 0, 0, 0, 0, 0, 0};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      x_dig = enc(xa[k]);
      y_dig = enc(ya[k]);
      @(posedge clk); #1;
    end
    x_dig = enc(xa[5]);
    y_dig = enc(ya[5]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_z_valid", int'(z_valid), 0);
    chk("abort_z_dig", int'(z_dig), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    quiet = 0;
    repeat (15) begin
      @(negedge clk);
      if (z_valid || done) quiet++;
    end
    chk("quiet_after_rst", quiet, 0);
    @(posedge clk); #1;
    do_op(xa, ya, 0, 1'b1, 64, 5, 1'b0);

    // start pulsed in RUN and in FLUSH is ignored
    xa = '{1, 1, 0, -1, 0, 0, 1, 0};
    ya = '{0, 1, -1, 0, 0, 1, 0, 1};
    do_op(xa, ya, 0, 1'b0, 0, 5, 1'b1);

    // random operands with stalls
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < N; k++) begin
        xa[k] = int'($urandom_range(2)) - 1;
        ya[k] = int'($urandom_range(2)) - 1;
      end
      do_op(xa, ya, 3, 1'b0, 0, -1, 1'b0);
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
